// File: rtl/falafel_mem_responder_if.sv
// Request/response bundle between the falafel core and its memory responder.
// Pure wiring, no latency.
// Request side uses val/rdy, response side uses val/rdy.
interface falafel_mem_responder_if #(
  parameter int DATA_W = 64
);
  logic              mem_req_val_i;
  logic              mem_req_rdy_o;
  logic              mem_req_is_write_i;
  logic              mem_req_is_cas_i;
  logic [DATA_W-1:0] mem_req_addr_i;
  logic [DATA_W-1:0] mem_req_data_i;
  logic [DATA_W-1:0] mem_req_cas_exp_i;
  logic              mem_rsp_val_o;
  logic              mem_rsp_rdy_i;
  logic [DATA_W-1:0] mem_rsp_data_o;

  // Core side: issues requests, consumes responses.
  modport master (
    output mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i,
    output mem_req_addr_i, mem_req_data_i, mem_req_cas_exp_i,
    input  mem_req_rdy_o,
    input  mem_rsp_val_o, mem_rsp_data_o,
    output mem_rsp_rdy_i
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i,
    input  mem_req_addr_i, mem_req_data_i, mem_req_cas_exp_i,
    output mem_req_rdy_o,
    output mem_rsp_val_o, mem_rsp_data_o,
    input  mem_rsp_rdy_i
  );
endinterface

// File: rtl/falafel_mem_responder.sv
// Word-addressed scratch memory answering read / write / CAS requests, one at a time.
// Response appears LATENCY cycles after the accept edge; one request per LATENCY+1 cycles.
// Request rdy is low until the response handshakes; the response is held while rsp_rdy is low.
module falafel_mem_responder #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  falafel_mem_responder_if.slave   bus,
  input  logic                     dbg_we_i,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0]        dbg_wdata_i,
  output logic [DATA_W-1:0]        dbg_rdata_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] old_word;
  logic              accept;
  logic              cas_hit;
  logic              req_we;
  logic              req_rdy;
  logic              rsp_val;
  logic              unused_addr_bits;

  // Byte address -> word index; low 3 bits and bits above the index are ignored (wrap).
  assign idx              = bus.mem_req_addr_i[3 +: AW];
  assign unused_addr_bits = ^{bus.mem_req_addr_i[2:0], bus.mem_req_addr_i[DATA_W-1:3+AW]};
  assign old_word         = mem[idx];

  // Everything is committed on the accept edge; the response is always the pre-update word.
  assign accept  = req_rdy && bus.mem_req_val_i;
  assign cas_hit = (old_word == bus.mem_req_cas_exp_i);
  assign req_we  = accept && bus.mem_req_is_write_i && (!bus.mem_req_is_cas_i || cas_hit);

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    req_rdy = 1'b0;
    rsp_val = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = !rst_i;
        if (req_rdy && bus.mem_req_val_i) begin
          rsp_d = old_word;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rsp_val = 1'b1;
        if (bus.mem_rsp_rdy_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter and captured response; reset drops any pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  // Memory array, not cleared by reset; a request write overrides a debug write to the same word.
  always_ff @(posedge clk_i) begin
    if (dbg_we_i) begin
      mem[dbg_addr_i] <= dbg_wdata_i;
    end
    if (req_we) begin
      mem[idx] <= bus.mem_req_data_i;
    end
  end

  assign bus.mem_req_rdy_o  = req_rdy;
  assign bus.mem_rsp_val_o  = rsp_val;
  assign bus.mem_rsp_data_o = rsp_val ? rsp_q : '0;
  assign dbg_rdata_o        = mem[dbg_addr_i];

endmodule
